servo_motion_sequencer: RTL and testbench

- Multi-channel position scheduler for the arm's servo PWM generators.
- Accepts per-channel target positions over a valid/ready command port and clamps them to the legal servo range.
- Once per servo frame, ramps each channel's current position one step toward its target (slew limiting), so joints never jump.
- Drives the 16-bit data and enable inputs of NUM_CH PWM instances; positions use the PWM duty encoding (25 = min pulse, 125 = max pulse).

---
 rtl/servo_pkg.sv | 21 ++
 rtl/servo_frame_timer.sv | 34 +++
 rtl/servo_motion_sequencer.sv | 140 ++++++++++++++
 tb/tb_servo_motion_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared servo constants: legal duty range, home position, PWM data width
// and the sequencer state encoding.
package servo_pkg;

    localparam int         POS_W    = 16;
    localparam logic [7:0] POS_MIN  = 8'd25;
    localparam logic [7:0] POS_MAX  = 8'd125;
    localparam logic [7:0] POS_HOME = 8'd75;

    typedef enum logic {
        ST_IDLE,
        ST_UPDATE
    } seq_state_t;

    function automatic logic [7:0] clamp_pos(input logic [7:0] p);
        if (p < POS_MIN) return POS_MIN;
        if (p > POS_MAX) return POS_MAX;
        return p;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame counter; frame_tick is a registered one-cycle pulse
// in the cycle after the counter reaches FRAME_CYCLES-1.
module servo_frame_timer #(
    parameter int FRAME_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic frame_tick
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == CNT_LAST);
        cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/servo_motion_sequencer.sv
// Per-channel servo position scheduler: clamped targets arrive over a
// valid/ready port, and each frame every enabled channel slews one STEP.
module servo_motion_sequencer
    import servo_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 2,
    parameter int FRAME_CYCLES = 1_000_000,
    parameter int STEP         = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CH_W-1:0]         cmd_ch,
    input  logic                    cmd_en,
    input  logic [7:0]              cmd_pos,
    input  logic                    halt,
    output logic [POS_W*NUM_CH-1:0] pos_out,
    output logic [NUM_CH-1:0]       en_out,
    output logic                    frame_tick,
    output logic                    busy,
    output logic                    cmd_err
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
    localparam logic [8:0]       STEP9    = 9'(STEP);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] ch_idx_q, ch_idx_d;
    logic [7:0]       pos_q [NUM_CH];
    logic [7:0]       pos_d [NUM_CH];
    logic [7:0]       tgt_q [NUM_CH];
    logic [7:0]       tgt_d [NUM_CH];
    logic [7:0]       step_pos [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] cmd_idx;
    logic             cmd_ch_ok;

    servo_frame_timer #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_frame_timer (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick)
    );

    assign cmd_idx   = cmd_ch[IDX_W-1:0];
    assign cmd_ch_ok = (int'(cmd_ch) < NUM_CH);

    // 9-bit step arithmetic so pos +/- STEP never wraps before the compare.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [8:0] p9, t9, up9, dn9;
        assign p9  = {1'b0, pos_q[gi]};
        assign t9  = {1'b0, tgt_q[gi]};
        assign up9 = p9 + STEP9;
        assign dn9 = p9 - STEP9;
        assign step_pos[gi] = (p9 < t9) ? ((up9 >= t9) ? tgt_q[gi] : up9[7:0]) :
                              (p9 > t9) ? ((p9 < STEP9 || dn9 <= t9) ? tgt_q[gi] : dn9[7:0]) :
                              pos_q[gi];
        assign pos_out[gi*POS_W +: POS_W] = {{(POS_W-8){1'b0}}, pos_q[gi]};
    end

    always_comb begin
        state_d   = state_q;
        ch_idx_d  = ch_idx_q;
        pos_d     = pos_q;
        tgt_d     = tgt_q;
        en_d      = en_q;
        err_d     = 1'b0;
        busy_d    = 1'b0;
        cmd_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (!cmd_ch_ok) begin
                        err_d = 1'b1;
                    end else if (cmd_en) begin
                        tgt_d[cmd_idx] = clamp_pos(cmd_pos);
                        en_d[cmd_idx]  = 1'b1;
                    end else begin
                        en_d[cmd_idx]  = 1'b0;
                    end
                end
                if (frame_tick) begin
                    state_d  = ST_UPDATE;
                    ch_idx_d = '0;
                end
            end
            ST_UPDATE: begin
                if (en_q[ch_idx_q] && !halt) begin
                    pos_d[ch_idx_q] = step_pos[ch_idx_q];
                end
                if (ch_idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    ch_idx_d = ch_idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // busy tracks the state being registered, so it never lags pos_out.
        for (int i = 0; i < NUM_CH; i++) begin
            if (en_d[i] && (pos_d[i] != tgt_d[i])) busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_idx_q <= '0;
            en_q     <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                pos_q[i] <= POS_HOME;
                tgt_q[i] <= POS_HOME;
            end
        end else begin
            state_q  <= state_d;
            ch_idx_q <= ch_idx_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            pos_q    <= pos_d;
            tgt_q    <= tgt_d;
        end
    end

    assign en_out  = en_q;
    assign busy    = busy_q;
    assign cmd_err = err_q;

endmodule

// File: tb/tb_servo_motion_sequencer.sv
// Randomized bench for servo_motion_sequencer checked every cycle against a
// frame-schedule reference model (FRAME_CYCLES=16, NUM_CH=4, CH_W=3).
module tb_servo_motion_sequencer;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 3;
    localparam int FC     = 16;
    localparam int STEP   = 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [CH_W-1:0]        cmd_ch;
    logic                   cmd_en;
    logic [7:0]             cmd_pos;
    logic                   halt;
    logic [16*NUM_CH-1:0]   pos_out;
    logic [NUM_CH-1:0]      en_out;
    logic                   frame_tick;
    logic                   busy;
    logic                   cmd_err;

    always #5 clk = ~clk;

    servo_motion_sequencer #(
        .NUM_CH      (NUM_CH),
        .CH_W        (CH_W),
        .FRAME_CYCLES(FC),
        .STEP        (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ch    (cmd_ch),
        .cmd_en    (cmd_en),
        .cmd_pos   (cmd_pos),
        .halt      (halt),
        .pos_out   (pos_out),
        .en_out    (en_out),
        .frame_tick(frame_tick),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: channel state plus the cycle index since reset release.
    int m_pos [NUM_CH];
    int m_tgt [NUM_CH];
    bit m_en  [NUM_CH];
    bit m_err;
    int n;

    // Pending command held on the port until it is accepted.
    bit       p_valid;
    int       p_ch;
    bit       p_en;
    int       p_pos;
    bit       halt_lvl;

    function automatic int clampv(input int p);
        return (p < 25) ? 25 : (p > 125) ? 125 : p;
    endfunction

    function automatic bit m_tick();
        return (n >= FC) && (n % FC == 0);
    endfunction

    function automatic bit m_ready();
        int ph = n % FC;
        return !((n >= FC) && (ph >= 1) && (ph <= NUM_CH));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_pos[i] = 75;
            m_tgt[i] = 75;
            m_en[i]  = 1'b0;
        end
        m_err   = 1'b0;
        p_valid = 1'b0;
    endtask

    task automatic check_all();
        logic [NUM_CH-1:0] exp_en;
        bit                exp_busy;
        exp_en   = '0;
        exp_busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            expect_eq($sformatf("pos%0d n=%0d", i, n), 32'(pos_out[16*i +: 16]), 32'(m_pos[i]));
            exp_en[i] = m_en[i];
            if (m_en[i] && m_pos[i] != m_tgt[i]) exp_busy = 1'b1;
        end
        expect_eq($sformatf("en_out n=%0d", n), 32'(en_out), 32'(exp_en));
        expect_eq($sformatf("busy n=%0d", n), 32'(busy), 32'(exp_busy));
        expect_eq($sformatf("cmd_ready n=%0d", n), 32'(cmd_ready), 32'(m_ready()));
        expect_eq($sformatf("frame_tick n=%0d", n), 32'(frame_tick), 32'(m_tick()));
        expect_eq($sformatf("cmd_err n=%0d", n), 32'(cmd_err), 32'(m_err));
    endtask

    // Check the current cycle, drive inputs, advance the model over the next edge.
    task automatic run_cycle();
        int ph;
        int c;
        check_all();
        cmd_valid = p_valid;
        cmd_ch    = CH_W'(p_ch);
        cmd_en    = p_en;
        cmd_pos   = 8'(p_pos);
        halt      = halt_lvl;
        m_err     = 1'b0;
        if (p_valid && m_ready()) begin
            $display("cmd n=%0d ch=%0d en=%0d pos=%0d", n, p_ch, p_en, p_pos);
            if (p_ch >= NUM_CH) begin
                m_err = 1'b1;
            end else if (p_en) begin
                m_tgt[p_ch] = clampv(p_pos);
                m_en[p_ch]  = 1'b1;
            end else begin
                m_en[p_ch]  = 1'b0;
            end
            p_valid = 1'b0;
        end
        ph = n % FC;
        if (n >= FC && ph >= 1 && ph <= NUM_CH) begin
            c = ph - 1;
            if (m_en[c] && !halt_lvl) begin
                if (m_pos[c] < m_tgt[c])      m_pos[c] = (m_pos[c] + STEP > m_tgt[c]) ? m_tgt[c] : m_pos[c] + STEP;
                else if (m_pos[c] > m_tgt[c]) m_pos[c] = (m_pos[c] - STEP < m_tgt[c]) ? m_tgt[c] : m_pos[c] - STEP;
            end
        end
        @(negedge clk);
        n++;
    endtask

    task automatic run_cycles(input int k);
        for (int i = 0; i < k; i++) run_cycle();
    endtask

    task automatic send(input int ch, input bit en, input int pos);
        p_valid = 1'b1;
        p_ch    = ch;
        p_en    = en;
        p_pos   = pos;
        for (int i = 0; i < 4 * FC && p_valid; i++) run_cycle();
        if (p_valid) begin
            miscompares++;
            $display("FAIL send_timeout: command ch=%0d never accepted", ch);
            p_valid = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < NUM_CH; i++)
            expect_eq($sformatf("%s pos%0d", tag, i), 32'(pos_out[16*i +: 16]), 32'd75);
        expect_eq({tag, " en_out"},     32'(en_out),     32'd0);
        expect_eq({tag, " cmd_ready"},  32'(cmd_ready),  32'd1);
        expect_eq({tag, " frame_tick"}, 32'(frame_tick), 32'd0);
        expect_eq({tag, " busy"},       32'(busy),       32'd0);
        expect_eq({tag, " cmd_err"},    32'(cmd_err),    32'd0);
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_en = 1'b0; cmd_pos = '0; halt = 1'b0;
        halt_lvl = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;

        // Idle for three frames, then a slow ramp on ch1 with a 3-frame halt.
        run_cycles(3 * FC + 6);
        send(1, 1'b1, 80);
        run_cycles(2 * FC);
        halt_lvl = 1'b1;
        run_cycles(3 * FC);
        halt_lvl = 1'b0;
        run_cycles(5 * FC);
        expect_eq("ramp_final_ch1", 32'(pos_out[31:16]), 32'd80);

        // Clamping at both ends of the legal range.
        send(0, 1'b1, 0);
        send(2, 1'b1, 200);
        run_cycles(52 * FC);
        expect_eq("clamp_low_ch0",  32'(pos_out[15:0]),  32'd25);
        expect_eq("clamp_high_ch2", 32'(pos_out[47:32]), 32'd125);

        // Out-of-range channel, then a command presented exactly on the tick cycle.
        send(5, 1'b1, 100);
        run_cycles(2);
        while (!m_tick()) run_cycle();
        send(3, 1'b1, 30);
        run_cycles(2 * FC);
        send(3, 1'b0, 100);
        run_cycles(FC);
        send(3, 1'b1, 30);
        run_cycles(FC);

        // Randomized traffic with occasional halt toggles.
        for (int i = 0; i < 1500; i++) begin
            if (!p_valid && $urandom_range(0, 3) == 0) begin
                p_valid = 1'b1;
                p_ch    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
                p_en    = ($urandom_range(0, 4) != 0);
                p_pos   = int'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 63) == 0) halt_lvl = ~halt_lvl;
            run_cycle();
        end
        halt_lvl = 1'b0;

        // Asynchronous reset in the middle of an update sequence.
        while ((n % FC) != 2 || n < FC) run_cycle();
        rst = 1'b1;
        #1 check_reset_outputs("reset_mid_update");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        send(2, 1'b1, 90);
        run_cycles(4 * FC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
